// File: rtl/systolic_deskew_collector.sv
// Drain side of the bit-serial systolic array: removes per-column skew, packs each
// wavefront into one COLS-bit word and queues it in a first-word fall-through FIFO.

module systolic_deskew_lane #(
    parameter int DLY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [DLY-1:0] sr;

    // Free-running: shifts every cycle whether or not a wavefront is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= (sr << 1) | DLY'(d);
    end

    assign q = sr[DLY-1];
endmodule

module systolic_deskew_collector #(
    parameter int COLS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [COLS-1:0]              in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS-1:0]              out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [COLS-1:0] word;
    logic            push;

    // Column j is delayed COLS-1-j cycles so all columns of a wavefront line up.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        if (j == COLS-1) begin : g_direct
            assign word[j] = in_data[j];
        end else begin : g_line
            systolic_deskew_lane #(.DLY(COLS-1-j)) u_lane (
                .clk (clk),
                .rst (rst),
                .d   (in_data[j]),
                .q   (word[j])
            );
        end
    end

    systolic_deskew_lane #(.DLY(COLS-1)) u_v_pipe (
        .clk (clk),
        .rst (rst),
        .d   (in_valid),
        .q   (push)
    );

    logic [DEPTH-1:0][COLS-1:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic                       full, pop, wr_en;

    assign full  = (count == CW'(DEPTH));
    assign pop   = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push & full & ~pop)
                overflow <= 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Directed bench for systolic_deskew_collector (COLS=8, DEPTH=4).

module tb_systolic_deskew_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic       sv [0:63];
    logic [7:0] sd [0:63];

    systolic_deskew_collector #(.COLS(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            sv[i] = 1'b0;
            sd[i] = '0;
        end
        cyc = 0;
    endtask

    // Wavefront started in cycle t: bit j of word is presented in cycle t+j.
    task automatic add_wave(input int t, input logic [7:0] w);
        sv[t] = 1'b1;
        for (int j = 0; j < 8; j++)
            sd[t+j][j] = w[j];
    endtask

    // Drive the current cycle's schedule, advance one clock, land 1 time unit past the edge.
    task automatic tick(input logic rdy);
        in_valid  = (cyc < 64) ? sv[cyc] : 1'b0;
        in_data   = (cyc < 64) ? sd[cyc] : 8'h00;
        out_ready = rdy;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sched();
    endtask

    task automatic drain(input string tag, input logic [7:0] w);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(w));
        tick(1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: single skewed wavefront 0xA5, eight-cycle latency
        add_wave(0, 8'hA5);
        repeat (7) tick(1'b0);
        chk("t1_early_valid", 32'(out_valid), 32'd0);
        tick(1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_count", 32'(count), 32'd1);
        tick(1'b0);
        chk("t1_hold_data", 32'(out_data), 32'hA5);
        tick(1'b1);
        chk("t1_count_after_pop", 32'(count), 32'd0);
        chk("t1_data_after_pop", 32'(out_data), 32'd0);

        // 2: unskewed 0xFF in cycle 0 only keeps just column 0
        do_reset();
        sv[0] = 1'b1;
        sd[0] = 8'hFF;
        repeat (8) tick(1'b0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'h01);
        tick(1'b1);

        // 3: four back-to-back wavefronts fill the FIFO in order
        do_reset();
        add_wave(0, 8'h01); add_wave(1, 8'h02); add_wave(2, 8'h04); add_wave(3, 8'h80);
        repeat (10) tick(1'b0);
        chk("t3_count_c10", 32'(count), 32'd3);
        tick(1'b0);
        chk("t3_count_c11", 32'(count), 32'd4);
        drain("t3_w0", 8'h01);
        drain("t3_w1", 8'h02);
        drain("t3_w2", 8'h04);
        drain("t3_w3", 8'h80);
        chk("t3_count_end", 32'(count), 32'd0);
        chk("t3_ovf", 32'(overflow), 32'd0);

        // 4: fifth wavefront against a stalled full FIFO is dropped
        do_reset();
        add_wave(0, 8'h01); add_wave(1, 8'h02); add_wave(2, 8'h04); add_wave(3, 8'h80);
        add_wave(4, 8'h3C);
        repeat (12) tick(1'b0);
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd1);
        drain("t4_w0", 8'h01);
        drain("t4_w1", 8'h02);
        drain("t4_w2", 8'h04);
        drain("t4_w3", 8'h80);
        chk("t4_count_end", 32'(count), 32'd0);
        chk("t4_valid_end", 32'(out_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: full FIFO with a pop on the same edge as the fifth push
        do_reset();
        add_wave(0, 8'h01); add_wave(1, 8'h02); add_wave(2, 8'h04); add_wave(3, 8'h80);
        add_wave(4, 8'h3C);
        repeat (11) tick(1'b0);
        chk("t5_full", 32'(count), 32'd4);
        tick(1'b1);
        chk("t5_count", 32'(count), 32'd4);
        chk("t5_ovf", 32'(overflow), 32'd0);
        drain("t5_w1", 8'h02);
        drain("t5_w2", 8'h04);
        drain("t5_w3", 8'h80);
        drain("t5_w4", 8'h3C);
        chk("t5_count_end", 32'(count), 32'd0);

        // 6: reset mid-wavefront discards it; a clean wavefront afterwards works
        do_reset();
        add_wave(0, 8'hFF);
        repeat (3) tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        repeat (10) tick(1'b0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        clear_sched();
        add_wave(0, 8'h5A);
        repeat (7) tick(1'b0);
        chk("t6_early_valid", 32'(out_valid), 32'd0);
        tick(1'b0);
        chk("t6_new_valid", 32'(out_valid), 32'd1);
        chk("t6_new_data", 32'(out_data), 32'h5A);
        chk("t6_new_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
